ann_load_ctrl: RTL

//  Responder side of the host load/start/done protocol of the ANN accelerator.

---
 rtl/ann_load_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ann_load_ctrl.sv
// ann_load_ctrl
// Responder side of the host load/start/done protocol for the ANN accelerator.
// The host streams bytes into a flat address space: the image occupies
// addresses 0..IMG_BYTES-1 and the parameters (weights/biases) follow directly
// after. Each accepted write is decoded onto either the image-RAM or the
// parameter-RAM write port one cycle later. A start pulse launches one
// inference on the core, and the result is held for the host until the next
// accepted write or start.
//
// Optional feature: define ANN_LOAD_WATCHDOG_EN to add a run-time watchdog.
// If the core does not report done within TIMEOUT_CYC cycles, the block
// forces final_class to all-ones, raises err and moves to DONE.

module ann_load_ctrl #(
   parameter int ADDR_W      = 14,
   parameter int IMG_BYTES   = 784,
   parameter int PARAM_BYTES = 13000,
   parameter int IMG_AW      = 10,
   parameter int PAR_AW      = 14,
   parameter int CLASS_W     = 4
`ifdef ANN_LOAD_WATCHDOG_EN
   ,
   parameter int TIMEOUT_CYC = 2**20
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [7:0]         wr_data,
   input  logic               start,
   output logic               img_we,
   output logic [IMG_AW-1:0]  img_addr,
   output logic               par_we,
   output logic [PAR_AW-1:0]  par_addr,
   output logic [7:0]         ram_wdata,
   output logic               core_start,
   input  logic               core_done,
   input  logic [CLASS_W-1:0] core_class,
   output logic [CLASS_W-1:0] final_class,
   output logic               done,
   output logic               busy,
   output logic               err
);

   // Region boundaries expressed at the host address width so that the
   // decode compares and the parameter offset subtract stay width-matched.
   localparam logic [ADDR_W-1:0] IMG_LIM = ADDR_W'(IMG_BYTES);
   localparam logic [ADDR_W-1:0] PAR_LIM = ADDR_W'(IMG_BYTES + PARAM_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q,       state_d;
   logic                 img_we_q,      img_we_d;
   logic [IMG_AW-1:0]    img_addr_q,    img_addr_d;
   logic                 par_we_q,      par_we_d;
   logic [PAR_AW-1:0]    par_addr_q,    par_addr_d;
   logic [7:0]           ram_wdata_q,   ram_wdata_d;
   logic                 core_start_q,  core_start_d;
   logic [CLASS_W-1:0]   final_class_q, final_class_d;
   logic                 done_q,        done_d;
   logic                 busy_q,        busy_d;
   logic                 err_q,         err_d;

   logic                 in_img;
   logic                 in_par;
   logic [ADDR_W-1:0]    par_off;

`ifdef ANN_LOAD_WATCHDOG_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

   // Address decode for the incoming write: which region it falls in and
   // its offset inside the parameter region.
   always_comb begin
      in_img  = (wr_addr < IMG_LIM);
      in_par  = !in_img && (wr_addr < PAR_LIM);
      par_off = wr_addr - IMG_LIM;
   end

   // Next-state logic: protocol FSM, write decode onto the RAM ports, result
   // capture and the sticky error flag. Writes take priority over start when
   // both arrive in the same cycle, and out-of-range writes do not count as
   // accepted, so they leave a held result in place.
   always_comb begin
      state_d       = state_q;
      img_we_d      = 1'b0;
      img_addr_d    = img_addr_q;
      par_we_d      = 1'b0;
      par_addr_d    = par_addr_q;
      ram_wdata_d   = ram_wdata_q;
      core_start_d  = 1'b0;
      final_class_d = final_class_q;
      err_d         = err_q;
`ifdef ANN_LOAD_WATCHDOG_EN
      cnt_d         = cnt_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            if (wr_en) begin
               if (in_img) begin
                  img_we_d    = 1'b1;
                  img_addr_d  = IMG_AW'(wr_addr);
                  ram_wdata_d = wr_data;
                  state_d     = IDLE;
               end else if (in_par) begin
                  par_we_d    = 1'b1;
                  par_addr_d  = PAR_AW'(par_off);
                  ram_wdata_d = wr_data;
                  state_d     = IDLE;
               end else begin
                  err_d = 1'b1;
               end
            end else if (start) begin
               state_d      = RUN;
               core_start_d = 1'b1;
`ifdef ANN_LOAD_WATCHDOG_EN
               cnt_d        = '0;
`endif
            end
         end

         RUN: begin
            if (wr_en) begin
               err_d = 1'b1;
            end
            if (core_done) begin
               final_class_d = core_class;
               state_d       = DONE;
`ifdef ANN_LOAD_WATCHDOG_EN
            end else if (cnt_q == CNT_LIM) begin
               final_class_d = '1;
               err_d         = 1'b1;
               state_d       = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and registered outputs, all cleared by the shared synchronous
   // reset so an inference in flight is simply abandoned.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         img_we_q      <= 1'b0;
         img_addr_q    <= '0;
         par_we_q      <= 1'b0;
         par_addr_q    <= '0;
         ram_wdata_q   <= '0;
         core_start_q  <= 1'b0;
         final_class_q <= '0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
`ifdef ANN_LOAD_WATCHDOG_EN
         cnt_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         img_we_q      <= img_we_d;
         img_addr_q    <= img_addr_d;
         par_we_q      <= par_we_d;
         par_addr_q    <= par_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         core_start_q  <= core_start_d;
         final_class_q <= final_class_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
`ifdef ANN_LOAD_WATCHDOG_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign img_we      = img_we_q;
   assign img_addr    = img_addr_q;
   assign par_we      = par_we_q;
   assign par_addr    = par_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign core_start  = core_start_q;
   assign final_class = final_class_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign err         = err_q;

endmodule
